// File: rtl/eight_reg_axil_pkg.sv
// Shared types and helpers for the eight-register AXI4-Lite slave.
// Combinational only: no latency, no backpressure.
package eight_reg_axil_pkg;

    localparam int NUM_REGS = 8;

    typedef logic [2:0] reg_idx_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/eight_reg_axil_regfile.sv
// Eight 32-bit registers: byte-strobe write, pre-edge read mux, one-hot write pulse.
// Write visible one cycle after wr_en; read is combinational; never stalls.
module eight_reg_axil_regfile
    import eight_reg_axil_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  reg_idx_t                wr_idx,
    input  logic [31:0]             wr_data,
    input  logic [3:0]              wr_strb,
    input  reg_idx_t                rd_idx,
    output logic [31:0]             rd_data,
    output logic [32*NUM_REGS-1:0]  regs,
    output logic [NUM_REGS-1:0]     wr_pulse
);

    logic [31:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) mem[k] <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (wr_en) begin
                mem[wr_idx]      <= apply_wstrb(mem[wr_idx], wr_data, wr_strb);
                wr_pulse[wr_idx] <= 1'b1;
            end
        end
    end

    // Read sees storage before the edge, so a same-edge write returns the old value.
    assign rd_data = mem[rd_idx];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
        assign regs[32*k +: 32] = mem[k];
    end

endmodule

// File: rtl/eight_reg_axil_slave.sv
// AXI4-Lite slave over eight registers; AW/W held independently, commit when both present.
// B/R valid one cycle after commit/AR handshake; readies drop while a response is pending.
module eight_reg_axil_slave
    import eight_reg_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [32*NUM_REGS-1:0]          regs_o,
    output logic [NUM_REGS-1:0]             wr_pulse_o
);

    logic                          rst_done;
    logic                          aw_held, w_held;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]                   w_data_q;
    logic [3:0]                    w_strb_q;
    logic                          bvalid, rvalid;
    axi_resp_t                     bresp, rresp;
    logic [31:0]                   rdata;

    logic                          aw_hs, w_hs, ar_hs, commit, wr_en;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [31:0]                   w_data, rd_data;
    logic [3:0]                    w_strb;

    // rst_done keeps the readies low during and at the edge leaving reset.
    assign S_AXI_AWREADY = rst_done && !aw_held && !bvalid;
    assign S_AXI_WREADY  = rst_done && !w_held  && !bvalid;
    assign S_AXI_ARREADY = rst_done && !rvalid;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    assign aw_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
    assign w_data  = w_held  ? w_data_q  : S_AXI_WDATA;
    assign w_strb  = w_held  ? w_strb_q  : S_AXI_WSTRB;
    assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_en   = commit && !aw_addr[5];

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rst_done  <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            rvalid    <= 1'b0;
            rresp     <= RESP_OKAY;
            rdata     <= '0;
        end else begin
            rst_done <= 1'b1;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= aw_addr[5] ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
                if (bvalid && S_AXI_BREADY) bvalid <= 1'b0;
            end
            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= S_AXI_ARADDR[5] ? 32'h0 : rd_data;
                rresp  <= S_AXI_ARADDR[5] ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid && S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    eight_reg_axil_regfile u_regfile (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .wr_en    (wr_en),
        .wr_idx   (aw_addr[4:2]),
        .wr_data  (w_data),
        .wr_strb  (w_strb),
        .rd_idx   (S_AXI_ARADDR[4:2]),
        .rd_data  (rd_data),
        .regs     (regs_o),
        .wr_pulse (wr_pulse_o)
    );

    assign S_AXI_BVALID = bvalid;
    assign S_AXI_BRESP  = bresp;
    assign S_AXI_RVALID = rvalid;
    assign S_AXI_RRESP  = rresp;
    assign S_AXI_RDATA  = rdata;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_eight_reg_axil_slave.sv
// Directed bench for eight_reg_axil_slave; expected values are hand-computed constants.
module tb_eight_reg_axil_slave;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic [5:0]   awaddr = '0;
    logic [2:0]   awprot = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [5:0]   araddr = '0;
    logic [2:0]   arprot = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [255:0] regs_o;
    logic [7:0]   wr_pulse_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_regs [8];

    always #5 ACLK = ~ACLK;

    eight_reg_axil_slave dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
    );

    function automatic logic [255:0] pack_exp();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = exp_regs[k];
        return v;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Full write with BREADY high; p1 is wr_pulse_o while BVALID is up, p2 the cycle after.
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [7:0] p1, output logic [7:0] p2);
        bit aw_done = 0, w_done = 0, aw_now, w_now;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1; wvalid = 1; bready = 1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            tick();
            if (aw_now) begin aw_done = 1; awvalid = 0; end
            if (w_now)  begin w_done = 1;  wvalid = 0;  end
            n++;
        end
        while (!bvalid && n < 40) begin tick(); n++; end
        checks++;
        if (!bvalid) begin
            errors++;
            $display("FAIL write_timeout: addr %h bvalid %b, required 1", a, bvalid);
        end
        resp = bresp;
        p1 = wr_pulse_o;
        tick();
        p2 = wr_pulse_o;
        bready = 0; awvalid = 0; wvalid = 0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit ar_done = 0, ar_now;
        int n = 0;
        araddr = a; arvalid = 1; rready = 0;
        while (!ar_done && n < 20) begin
            ar_now = arvalid && arready;
            tick();
            if (ar_now) begin ar_done = 1; arvalid = 0; end
            n++;
        end
        while (!rvalid && n < 40) begin tick(); n++; end
        checks++;
        if (!rvalid) begin
            errors++;
            $display("FAIL read_timeout: addr %h rvalid %b, required 1", a, rvalid);
        end
        d = rdata; resp = rresp;
        rready = 1;
        tick();
        rready = 0; arvalid = 0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 8; k++) exp_regs[k] = '0;
        ARESETN = 0;
        repeat (3) tick();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake: aw/w/ar rdy b/r vld %b, required 00000",
                     {awready, wready, arready, bvalid, rvalid});
        end
        checks++;
        if (regs_o !== 256'h0 || wr_pulse_o !== 8'h0) begin
            errors++;
            $display("FAIL reset_regs: regs %h pulse %h, required 0", regs_o, wr_pulse_o);
        end
        checks++;
        if (bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp: bresp %b rresp %b rdata %h, required 0", bresp, rresp, rdata);
        end
        ARESETN = 1;
        checks++;
        if (awready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early: awready %b, required 0", awready);
        end
        tick();
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready_after: %b, required 111", {awready, wready, arready});
        end
    endtask

    task automatic test_sequential();
        logic [1:0] r;
        logic [7:0] p1, p2;
        logic [31:0] d;
        for (int k = 0; k < 4; k++) begin
            axi_write(6'(4*k), 32'(k+1), 4'hF, r, p1, p2);
            exp_regs[k] = 32'(k+1);
            checks++;
            if (r !== 2'b00) begin
                errors++;
                $display("FAIL seq_bresp[%0d]: %b, required 00", k, r);
            end
        end
        for (int k = 0; k < 4; k++) begin
            axi_read(6'(4*k), d, r);
            checks++;
            if (d !== 32'(k+1) || r !== 2'b00) begin
                errors++;
                $display("FAIL seq_read[%0d]: data %h resp %b, required %h 00", k, d, r, k+1);
            end
        end
        checks++;
        if (regs_o[127:0] !== 128'h00000004_00000003_00000002_00000001) begin
            errors++;
            $display("FAIL seq_regs_o: %h, required 00000004000000030000000200000001", regs_o[127:0]);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] r;
        logic [7:0] p1, p2;
        logic [31:0] d;
        axi_write(6'h10, 32'hFFFF_FFFF, 4'hF, r, p1, p2);
        checks++;
        if (p1 !== 8'h10 || p2 !== 8'h00) begin
            errors++;
            $display("FAIL strobe_pulse_full: %h then %h, required 10 then 00", p1, p2);
        end
        axi_write(6'h10, 32'h00AB_0000, 4'b0100, r, p1, p2);
        exp_regs[4] = 32'hFFAB_FFFF;
        checks++;
        if (p1 !== 8'h10 || p2 !== 8'h00) begin
            errors++;
            $display("FAIL strobe_pulse_part: %h then %h, required 10 then 00", p1, p2);
        end
        axi_read(6'h10, d, r);
        checks++;
        if (d !== 32'hFFAB_FFFF || r !== 2'b00) begin
            errors++;
            $display("FAIL strobe_read: %h %b, required ffabffff 00", d, r);
        end
        axi_write(6'h18, 32'h1234_5678, 4'b0000, r, p1, p2);
        checks++;
        if (r !== 2'b00 || p1 !== 8'h40 || regs_o !== pack_exp()) begin
            errors++;
            $display("FAIL strobe_zero: resp %b pulse %h r6 %h, required 00 40 00000000", r, p1, regs_o[223:192]);
        end
    endtask

    task automatic test_split_write();
        wdata = 32'hCAFE_0001; wstrb = 4'hF; wvalid = 1;
        tick();
        wvalid = 0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (wready !== 1'b0 || bvalid !== 1'b0) begin
                errors++;
                $display("FAIL split_wait[%0d]: wready %b bvalid %b, required 0 0", i, wready, bvalid);
            end
            tick();
        end
        awaddr = 6'h1C; awvalid = 1;
        checks++;
        if (wready !== 1'b0 || awready !== 1'b1) begin
            errors++;
            $display("FAIL split_ready: wready %b awready %b, required 0 1", wready, awready);
        end
        tick();
        awvalid = 0;
        exp_regs[7] = 32'hCAFE_0001;
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || regs_o !== pack_exp()) begin
            errors++;
            $display("FAIL split_commit: bvalid %b bresp %b r7 %h, required 1 00 cafe0001", bvalid, bresp, regs_o[255:224]);
        end
        bready = 1;
        tick();
        bready = 0;
    endtask

    task automatic test_backpressure();
        bit bad;
        logic [31:0] d;
        logic [1:0] r;
        awaddr = 6'h14; wdata = 32'h0000_0055; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; bready = 0;
        tick();
        awaddr = 6'h00; wdata = 32'hDEAD_BEEF;
        exp_regs[5] = 32'h55;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) bad = 1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL b_stall: bvalid %b bresp %b awready %b wready %b, required 1 00 0 0",
                     bvalid, bresp, awready, wready);
        end
        awvalid = 0; wvalid = 0; bready = 1;
        tick();
        bready = 0;
        checks++;
        if (bvalid !== 1'b0 || regs_o !== pack_exp()) begin
            errors++;
            $display("FAIL b_release: bvalid %b r5 %h r0 %h, required 0 00000055 00000001",
                     bvalid, regs_o[191:160], regs_o[31:0]);
        end
        araddr = 6'h04; arvalid = 1; rready = 0;
        tick();
        araddr = 6'h08;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (rvalid !== 1'b1 || rdata !== 32'h2 || rresp !== 2'b00 || arready !== 1'b0) bad = 1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL r_stall: rvalid %b rdata %h arready %b, required 1 00000002 0", rvalid, rdata, arready);
        end
        arvalid = 0; rready = 1;
        tick();
        rready = 0;
        axi_read(6'h14, d, r);
        checks++;
        if (d !== 32'h55 || r !== 2'b00) begin
            errors++;
            $display("FAIL r_after_stall: %h %b, required 00000055 00", d, r);
        end
    endtask

    task automatic test_slverr();
        logic [1:0] r;
        logic [7:0] p1, p2;
        logic [31:0] d;
        axi_write(6'h24, 32'h1111_1111, 4'hF, r, p1, p2);
        checks++;
        if (r !== 2'b10 || p1 !== 8'h00 || regs_o !== pack_exp()) begin
            errors++;
            $display("FAIL slverr_write: resp %b pulse %h regs %h", r, p1, regs_o);
        end
        axi_read(6'h24, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            errors++;
            $display("FAIL slverr_read: %h %b, required 00000000 10", d, r);
        end
    endtask

    task automatic test_same_edge();
        awaddr = 6'h00; wdata = 32'h99; wstrb = 4'hF; araddr = 6'h00;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 0;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        exp_regs[0] = 32'h99;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h1 || bvalid !== 1'b1 || regs_o !== pack_exp()) begin
            errors++;
            $display("FAIL same_edge: rvalid %b rdata %h bvalid %b r0 %h, required 1 00000001 1 00000099",
                     rvalid, rdata, bvalid, regs_o[31:0]);
        end
        rready = 1;
        tick();
        bready = 0; rready = 0;
    endtask

    task automatic test_reset_midflight();
        logic [1:0] r;
        logic [7:0] p1, p2;
        logic [31:0] d;
        awaddr = 6'h08; wdata = 32'h77; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; bready = 0;
        tick();
        awvalid = 0; wvalid = 0;
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pending: bvalid %b, required 1", bvalid);
        end
        ARESETN = 0;
        tick();
        for (int k = 0; k < 8; k++) exp_regs[k] = '0;
        checks++;
        if (bvalid !== 1'b0 || regs_o !== 256'h0 || awready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: bvalid %b awready %b regs %h, required 0 0 0", bvalid, awready, regs_o);
        end
        ARESETN = 1;
        tick();
        axi_write(6'h04, 32'h1234, 4'hF, r, p1, p2);
        exp_regs[1] = 32'h1234;
        checks++;
        if (r !== 2'b00 || p1 !== 8'h02 || regs_o !== pack_exp()) begin
            errors++;
            $display("FAIL mid_write_after: resp %b pulse %h r1 %h, required 00 02 00001234", r, p1, regs_o[63:32]);
        end
        axi_read(6'h04, d, r);
        checks++;
        if (d !== 32'h1234 || r !== 2'b00) begin
            errors++;
            $display("FAIL mid_read_after: %h %b, required 00001234 00", d, r);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_strobe();
        test_split_write();
        test_backpressure();
        test_slverr();
        test_same_edge();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
